// File: rtl/ebpc_pkg.sv
// Shared types and constants for the EBPC encoder back end.
// The source tag enum is carried on the merged stream and is also
// used internally as the round-robin grant.

package ebpc_pkg;

    // Word width of every EBPC stream port.
    localparam int DATA_W = 8;

    // Which encoder stream a word came from.
    typedef enum logic {
        SRC_ZNZ = 1'b0,
        SRC_BPC = 1'b1
    } ebpc_src_e;

    // The opposite source; there are only two requesters.
    function automatic ebpc_src_e other_src(input ebpc_src_e s);
        ebpc_src_e o;
        case (s)
            SRC_ZNZ: o = SRC_BPC;
            SRC_BPC: o = SRC_ZNZ;
            default: o = SRC_ZNZ;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/ebpc_stream_mux_if.sv
// Valid/ready word stream with a source tag.
// The master drives data/src/vld and samples rdy; the slave does the opposite.
// The tag is meaningful on the merged stream only; encoder-side
// producers simply tie it to their own source.

interface ebpc_stream_mux_if #(
    parameter int W = ebpc_pkg::DATA_W
);
    import ebpc_pkg::*;

    logic [W-1:0] data;
    ebpc_src_e    src;
    logic         vld;
    logic         rdy;

    modport master (output data, output src, output vld, input rdy);
    modport slave  (input data, input src, input vld, output rdy);

endinterface

// File: rtl/ebpc_rr_arb.sv
// Two-requester round-robin arbiter with a bounded burst length.
// The current grant keeps winning until it has won MAX_BURST times
// in a row while the other requester is waiting. Grant and burst
// counter advance only when the pick is actually accepted, so stall
// cycles leave the arbitration state frozen.

module ebpc_rr_arb
    import ebpc_pkg::*;
#(
    parameter int MAX_BURST = 4,
    localparam int CNT_W = $clog2(MAX_BURST + 1)
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    input  logic [1:0] vld_i,        // indexed by ebpc_src_e
    input  logic      accept_en_i,   // pick is consumed this cycle if valid
    output ebpc_src_e pick_o,
    output logic      pick_vld_o
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

    ebpc_src_e        grant_q;
    ebpc_src_e        grant_d_s;
    logic [CNT_W-1:0] burst_cnt_q;
    logic [CNT_W-1:0] burst_cnt_d_s;
    ebpc_src_e        other_s;
    ebpc_src_e        pick_s;
    logic             pick_vld_s;
    logic             grant_vld_s;
    logic             other_vld_s;
    logic             burst_open_s;

    // Choose the requester to serve this cycle.
    always_comb begin
        other_s      = other_src(grant_q);
        grant_vld_s  = vld_i[grant_q];
        other_vld_s  = vld_i[other_s];
        burst_open_s = (burst_cnt_q < MAX_CNT);
        pick_s       = grant_q;
        pick_vld_s   = 1'b0;
        if (grant_vld_s && (burst_open_s || !other_vld_s)) begin
            pick_s     = grant_q;
            pick_vld_s = 1'b1;
        end else if (other_vld_s) begin
            pick_s     = other_s;
            pick_vld_s = 1'b1;
        end else begin
            pick_s     = grant_q;
            pick_vld_s = 1'b0;
        end
    end

    // Next grant and burst count; only an accepted pick moves them.
    always_comb begin
        grant_d_s     = grant_q;
        burst_cnt_d_s = burst_cnt_q;
        if (accept_en_i && pick_vld_s) begin
            if (pick_s == grant_q) begin
                grant_d_s = grant_q;
                if (burst_cnt_q == MAX_CNT) begin
                    burst_cnt_d_s = burst_cnt_q;
                end else begin
                    burst_cnt_d_s = burst_cnt_q + CNT_W'(1);
                end
            end else begin
                grant_d_s     = pick_s;
                burst_cnt_d_s = CNT_W'(1);
            end
        end else begin
            grant_d_s     = grant_q;
            burst_cnt_d_s = burst_cnt_q;
        end
    end

    // Arbitration state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            grant_q     <= SRC_ZNZ;
            burst_cnt_q <= {CNT_W{1'b0}};
        end else begin
            grant_q     <= grant_d_s;
            burst_cnt_q <= burst_cnt_d_s;
        end
    end

    assign pick_o     = pick_s;
    assign pick_vld_o = pick_vld_s;

endmodule

// File: rtl/ebpc_stream_mux.sv
// Merges the EBPC encoder's ZNZ and BPC output streams onto a single
// registered, source-tagged stream. One output register stage; it
// reloads whenever it is empty or being drained, so ready flows
// combinationally from the downstream port and a steady one word per
// cycle is sustained.

module ebpc_stream_mux
    import ebpc_pkg::*;
#(
    parameter int DATA_W    = ebpc_pkg::DATA_W,
    parameter int MAX_BURST = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    ebpc_stream_mux_if.slave        znz,
    ebpc_stream_mux_if.slave        bpc,
    ebpc_stream_mux_if.master       merged,
    output logic                    idle_o
);

    logic [DATA_W-1:0] data_r;
    ebpc_src_e         src_r;
    logic              vld_r;

    logic              load_en_s;
    logic [1:0]        vld_pair_s;
    ebpc_src_e         pick_s;
    logic              pick_vld_s;
    logic [DATA_W-1:0] pick_data_s;
    logic              znz_rdy_s;
    logic              bpc_rdy_s;

    assign load_en_s  = !vld_r || merged.rdy;
    assign vld_pair_s = {bpc.vld, znz.vld};

    ebpc_rr_arb #(
        .MAX_BURST (MAX_BURST)
    ) u_arb (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .vld_i       (vld_pair_s),
        .accept_en_i (load_en_s),
        .pick_o      (pick_s),
        .pick_vld_o  (pick_vld_s)
    );

    // Only the picked source sees ready, and only when the register can load.
    always_comb begin
        znz_rdy_s = 1'b0;
        bpc_rdy_s = 1'b0;
        if (load_en_s && pick_vld_s) begin
            case (pick_s)
                SRC_ZNZ: znz_rdy_s = 1'b1;
                SRC_BPC: bpc_rdy_s = 1'b1;
                default: begin
                    znz_rdy_s = 1'b0;
                    bpc_rdy_s = 1'b0;
                end
            endcase
        end else begin
            znz_rdy_s = 1'b0;
            bpc_rdy_s = 1'b0;
        end
    end

    // Data of the picked source.
    always_comb begin
        pick_data_s = znz.data;
        case (pick_s)
            SRC_ZNZ: pick_data_s = znz.data;
            SRC_BPC: pick_data_s = bpc.data;
            default: pick_data_s = znz.data;
        endcase
    end

    // Output register: load on accept, empty when nothing is picked, hold on stall.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_r <= {DATA_W{1'b0}};
            src_r  <= SRC_ZNZ;
            vld_r  <= 1'b0;
        end else if (load_en_s) begin
            if (pick_vld_s) begin
                data_r <= pick_data_s;
                src_r  <= pick_s;
                vld_r  <= 1'b1;
            end else begin
                data_r <= data_r;
                src_r  <= src_r;
                vld_r  <= 1'b0;
            end
        end else begin
            data_r <= data_r;
            src_r  <= src_r;
            vld_r  <= vld_r;
        end
    end

    assign znz.rdy     = znz_rdy_s;
    assign bpc.rdy     = bpc_rdy_s;
    assign merged.data = data_r;
    assign merged.src  = src_r;
    assign merged.vld  = vld_r;
    assign idle_o      = !vld_r && !znz.vld && !bpc.vld;

endmodule

// File: tb/tb_ebpc_stream_mux.sv
// Directed and randomised checks of the ZNZ/BPC stream merger.

module tb_ebpc_stream_mux;
    import ebpc_pkg::*;

    localparam int MAX_BURST = 4;

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    logic idle;

    always #5 clk = ~clk;

    ebpc_stream_mux_if znz_if ();
    ebpc_stream_mux_if bpc_if ();
    ebpc_stream_mux_if out_if ();

    ebpc_stream_mux #(
        .DATA_W    (8),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .znz    (znz_if),
        .bpc    (bpc_if),
        .merged (out_if),
        .idle_o (idle)
    );

    int n_checks = 0;
    int n_fails  = 0;
    int cyc      = 0;

    logic [7:0] zq[$];
    logic [7:0] bq[$];
    logic       z_en = 1'b0;
    logic       b_en = 1'b0;
    logic [8:0] out_log[$];
    int         out_cyc[$];
    int         zacc_cyc[$];
    int         bpc_rdy_hi = 0;
    logic       run_src = 1'b0;
    int         run_len = 0;
    int         run_viol = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic drive();
        znz_if.src  = SRC_ZNZ;
        bpc_if.src  = SRC_BPC;
        znz_if.vld  = z_en && (zq.size() > 0);
        znz_if.data = (zq.size() > 0) ? zq[0] : 8'h00;
        bpc_if.vld  = b_en && (bq.size() > 0);
        bpc_if.data = (bq.size() > 0) ? bq[0] : 8'h00;
    endtask

    // One clock: sample handshakes before the edge, update the model after it.
    task automatic tick();
        logic zf, bf, of, s, other_v;
        logic [8:0] ow;
        #1;
        zf = znz_if.vld && znz_if.rdy;
        bf = bpc_if.vld && bpc_if.rdy;
        of = out_if.vld && out_if.rdy;
        ow = {out_if.src, out_if.data};
        if (bpc_if.rdy) bpc_rdy_hi++;
        if (zf || bf) begin
            s       = bf;
            other_v = bf ? znz_if.vld : bpc_if.vld;
            if (run_len > 0 && run_src == s) run_len++;
            else begin
                run_src = s;
                run_len = 1;
            end
            if (run_len > MAX_BURST && other_v) run_viol++;
        end
        @(posedge clk);
        cyc++;
        #1;
        if (zf) begin
            void'(zq.pop_front());
            zacc_cyc.push_back(cyc);
        end
        if (bf) void'(bq.pop_front());
        if (of) begin
            out_log.push_back(ow);
            out_cyc.push_back(cyc);
        end
        drive();
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        z_en = 1'b0;
        b_en = 1'b0;
        zq.delete();
        bq.delete();
        out_if.rdy = 1'b1;
        drive();
        repeat (2) @(posedge clk);
        #1;
        rst_ni = 1'b1;
        out_log.delete();
        out_cyc.delete();
        zacc_cyc.delete();
        bpc_rdy_hi = 0;
        run_len = 0;
    endtask

    task automatic drain(input string tag, input int max_cyc);
        int n;
        n = 0;
        out_if.rdy = 1'b1;
        drive();
        while ((zq.size() > 0 || bq.size() > 0 || out_if.vld) && n < max_cyc) begin
            tick();
            n++;
        end
        check_eq({tag, "_drained"}, zq.size() + bq.size() + int'(out_if.vld), 0);
    endtask

    initial begin
        int zn, bn, zexp, bexp, zout, bout, ord_err;
        logic [8:0] e;

        // Reset state
        do_reset();
        check_eq("rst_vld", out_if.vld, 0);
        check_eq("rst_data", out_if.data, 0);
        check_eq("rst_src", out_if.src, 0);
        check_eq("rst_idle", idle, 1);
        check_eq("rst_grant", dut.u_arb.grant_q, 0);
        check_eq("rst_cnt", dut.u_arb.burst_cnt_q, 0);

        // ZNZ only, 10 words
        for (int i = 1; i <= 10; i++) zq.push_back(8'(i));
        z_en = 1'b1;
        drive();
        #1;
        check_eq("t1_idle_busy", idle, 0);
        drain("t1", 100);
        check_eq("t1_count", out_log.size(), 10);
        for (int k = 0; k < out_log.size(); k++)
            check_eq($sformatf("t1_word%0d", k), out_log[k], {1'b0, 8'(k + 1)});
        if (out_log.size() == 10 && zacc_cyc.size() > 0) begin
            check_eq("t1_contig", out_cyc[9] - out_cyc[0], 9);
            check_eq("t1_latency", out_cyc[0] - zacc_cyc[0], 1);
        end
        check_eq("t1_bpc_rdy", bpc_rdy_hi, 0);
        check_eq("t1_idle_end", idle, 1);

        // Both valid from reset: bursts of four
        do_reset();
        for (int i = 0; i < 12; i++) begin
            zq.push_back(8'(8'h10 + i));
            bq.push_back(8'(8'h80 + i));
        end
        z_en = 1'b1;
        b_en = 1'b1;
        drive();
        drain("t2", 100);
        check_eq("t2_count", out_log.size(), 24);
        for (int k = 0; k < out_log.size(); k++) begin
            int blk, idx;
            blk = k / 4;
            idx = (blk / 2) * 4 + (k % 4);
            e = (blk % 2 == 1) ? {1'b1, 8'(8'h80 + idx)} : {1'b0, 8'(8'h10 + idx)};
            check_eq($sformatf("t2_word%0d", k), out_log[k], e);
        end
        if (out_log.size() == 24) check_eq("t2_contig", out_cyc[23] - out_cyc[0], 23);

        // ZNZ runs dry after two words while BPC waits
        do_reset();
        zq.push_back(8'h21);
        zq.push_back(8'h22);
        bq.push_back(8'hA1);
        bq.push_back(8'hA2);
        bq.push_back(8'hA3);
        z_en = 1'b1;
        b_en = 1'b1;
        drive();
        repeat (3) tick();
        check_eq("t3_grant", dut.u_arb.grant_q, 1);
        check_eq("t3_cnt", dut.u_arb.burst_cnt_q, 1);
        drain("t3", 50);
        check_eq("t3_count", out_log.size(), 5);
        if (out_log.size() == 5) begin
            check_eq("t3_w0", out_log[0], 9'h021);
            check_eq("t3_w1", out_log[1], 9'h022);
            check_eq("t3_w2", out_log[2], 9'h1A1);
            check_eq("t3_w3", out_log[3], 9'h1A2);
            check_eq("t3_w4", out_log[4], 9'h1A3);
            check_eq("t3_contig", out_cyc[4] - out_cyc[0], 4);
        end

        // Downstream stall with a word held
        do_reset();
        for (int i = 0; i < 4; i++) zq.push_back(8'(8'h31 + i));
        z_en = 1'b1;
        drive();
        repeat (2) tick();
        out_if.rdy = 1'b0;
        for (int s = 0; s < 5; s++) begin
            tick();
            #1;
            check_eq($sformatf("t4_data%0d", s), out_if.data, 8'h32);
            check_eq($sformatf("t4_src%0d", s), out_if.src, 0);
            check_eq($sformatf("t4_vld%0d", s), out_if.vld, 1);
            check_eq($sformatf("t4_zrdy%0d", s), znz_if.rdy, 0);
            check_eq($sformatf("t4_brdy%0d", s), bpc_if.rdy, 0);
            check_eq($sformatf("t4_cnt%0d", s), dut.u_arb.burst_cnt_q, 2);
        end
        drain("t4", 50);
        check_eq("t4_count", out_log.size(), 4);
        for (int k = 0; k < out_log.size(); k++)
            check_eq($sformatf("t4_word%0d", k), out_log[k], {1'b0, 8'(8'h31 + k)});

        // Asynchronous reset mid-burst
        do_reset();
        for (int i = 0; i < 8; i++) begin
            zq.push_back(8'(8'h50 + i));
            bq.push_back(8'(8'hD0 + i));
        end
        z_en = 1'b1;
        b_en = 1'b1;
        drive();
        repeat (6) tick();
        check_eq("t5_pre_grant", dut.u_arb.grant_q, 1);
        check_eq("t5_pre_vld", out_if.vld, 1);
        rst_ni = 1'b0;
        #1;
        check_eq("t5_vld", out_if.vld, 0);
        check_eq("t5_grant", dut.u_arb.grant_q, 0);
        check_eq("t5_cnt", dut.u_arb.burst_cnt_q, 0);
        do_reset();
        zq.push_back(8'h41);
        bq.push_back(8'hC1);
        z_en = 1'b1;
        b_en = 1'b1;
        drive();
        drain("t5", 20);
        check_eq("t5_count", out_log.size(), 2);
        if (out_log.size() == 2) begin
            check_eq("t5_first", out_log[0], 9'h041);
            check_eq("t5_second", out_log[1], 9'h1C1);
        end

        // Random valid/ready traffic with scoreboard
        do_reset();
        zn = 0;
        bn = 0;
        for (int c = 0; c < 10000; c++) begin
            if (zq.size() < 2) begin
                zq.push_back(8'(zn));
                zn++;
            end
            if (bq.size() < 2) begin
                bq.push_back(8'(bn) ^ 8'hA5);
                bn++;
            end
            z_en = ($urandom_range(0, 3) != 0);
            b_en = ($urandom_range(0, 3) != 0);
            out_if.rdy = ($urandom_range(0, 3) != 0);
            drive();
            tick();
        end
        z_en = 1'b1;
        b_en = 1'b1;
        drain("t6", 200);
        zexp = 0;
        bexp = 0;
        zout = 0;
        bout = 0;
        ord_err = 0;
        foreach (out_log[k]) begin
            if (out_log[k][8] == 1'b0) begin
                if (out_log[k][7:0] !== 8'(zexp)) ord_err++;
                zexp++;
                zout++;
            end else begin
                if (out_log[k][7:0] !== (8'(bexp) ^ 8'hA5)) ord_err++;
                bexp++;
                bout++;
            end
        end
        check_eq("t6_order", ord_err, 0);
        check_eq("t6_znz_count", zout, zn);
        check_eq("t6_bpc_count", bout, bn);
        check_eq("t6_burst", run_viol, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
